// File: rtl/scs8hd_lpflow_pwrseq_ctrl_if.sv
// Power-sequencer handshake bundle: sleep request / rail status in,
// isolation, retention and switch controls out.
interface scs8hd_lpflow_pwrseq_ctrl_if;
    logic sleep_req;
    logic pwr_good;
    logic sleep_ack;
    logic iso_en;
    logic ret_save;
    logic ret_restore;
    logic sw_enb;
    logic busy;
    logic err;

    // Controller side
    modport slave (
        input  sleep_req, pwr_good,
        output sleep_ack, iso_en, ret_save, ret_restore, sw_enb, busy, err
    );

    // Requester / power-management side
    modport master (
        output sleep_req, pwr_good,
        input  sleep_ack, iso_en, ret_save, ret_restore, sw_enb, busy, err
    );
endinterface

// File: rtl/scs8hd_lpflow_pwrseq_ctrl.sv
// Power-gating sequencer: isolate -> save -> switch off -> OFF, and
// switch on -> wait pwr_good -> restore -> de-isolate -> ON.
// One 8-bit down counter times every stage; outputs are registered from
// the next-state decode so they line up with the state register.
module scs8hd_lpflow_pwrseq_ctrl #(
    parameter int ISO_DLY = 2,
    parameter int RET_DLY = 2,
    parameter int SW_DLY  = 8,
    parameter int TMO     = 64
) (
    input  logic                          clk,
    input  logic                          resetb,
    scs8hd_lpflow_pwrseq_ctrl_if.slave    bus
);

    localparam logic [2:0] S_ON      = 3'd0;
    localparam logic [2:0] S_ISO     = 3'd1;
    localparam logic [2:0] S_SAVE    = 3'd2;
    localparam logic [2:0] S_SWOFF   = 3'd3;
    localparam logic [2:0] S_OFF     = 3'd4;
    localparam logic [2:0] S_SWON    = 3'd5;
    localparam logic [2:0] S_RESTORE = 3'd6;
    localparam logic [2:0] S_DEISO   = 3'd7;

    logic [2:0] state, nxt_state;
    logic [7:0] cnt, nxt_cnt;
    logic       nxt_err;

    // Counter preload for the stage being entered (stage length minus one)
    function automatic logic [7:0] load_val(input logic [2:0] s);
        case (s)
            S_ISO, S_DEISO:     load_val = 8'(ISO_DLY - 1);
            S_SAVE, S_RESTORE:  load_val = 8'(RET_DLY - 1);
            S_SWOFF:            load_val = 8'(SW_DLY - 1);
            S_SWON:             load_val = 8'(TMO - 1);
            default:            load_val = 8'd0;
        endcase
    endfunction

    // Next state, counter and sticky timeout flag
    always_comb begin
        nxt_state = state;
        nxt_cnt   = (cnt != 8'd0) ? cnt - 8'd1 : cnt;
        nxt_err   = bus.err;
        case (state)
            S_ON:      if (bus.sleep_req)  nxt_state = S_ISO;
            S_ISO:     if (cnt == 8'd0)    nxt_state = S_SAVE;
            S_SAVE:    if (cnt == 8'd0)    nxt_state = S_SWOFF;
            S_SWOFF:   if (cnt == 8'd0)    nxt_state = S_OFF;
            S_OFF:     if (!bus.sleep_req) nxt_state = S_SWON;
            S_SWON: begin
                // Timeout only flags; we keep waiting for the rail.
                if (bus.pwr_good)          nxt_state = S_RESTORE;
                else if (cnt == 8'd0)      nxt_err   = 1'b1;
            end
            S_RESTORE: if (cnt == 8'd0)    nxt_state = S_DEISO;
            S_DEISO:   if (cnt == 8'd0)    nxt_state = S_ON;
            default:                       nxt_state = S_ON;
        endcase
        if (nxt_state != state)
            nxt_cnt = load_val(nxt_state);
    end

    // State, counter and registered Moore output decode
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state           <= S_ON;
            cnt             <= 8'd0;
            bus.err         <= 1'b0;
            bus.sleep_ack   <= 1'b0;
            bus.iso_en      <= 1'b0;
            bus.ret_save    <= 1'b0;
            bus.ret_restore <= 1'b0;
            bus.sw_enb      <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state           <= nxt_state;
            cnt             <= nxt_cnt;
            bus.err         <= nxt_err;
            bus.sleep_ack   <= (nxt_state == S_OFF);
            bus.iso_en      <= (nxt_state != S_ON);
            bus.ret_save    <= (nxt_state == S_SAVE);
            bus.ret_restore <= (nxt_state == S_RESTORE);
            bus.sw_enb      <= (nxt_state == S_SWOFF) || (nxt_state == S_OFF);
            bus.busy        <= (nxt_state != S_ON) && (nxt_state != S_OFF);
        end
    end

endmodule

// File: tb/tb_scs8hd_lpflow_pwrseq_ctrl.sv
// Bench for the power sequencer: vector table over a full sleep/wake with
// default parameters, plus hand sequences for pulse request, pwr_good
// timeout, mid-sequence reset and all-ones parameters.
module tb_scs8hd_lpflow_pwrseq_ctrl;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    scs8hd_lpflow_pwrseq_ctrl_if b0();
    scs8hd_lpflow_pwrseq_ctrl_if b1();
    scs8hd_lpflow_pwrseq_ctrl_if b2();

    scs8hd_lpflow_pwrseq_ctrl d0 (.clk(clk), .resetb(resetb), .bus(b0));
    scs8hd_lpflow_pwrseq_ctrl #(.TMO(4)) d1 (.clk(clk), .resetb(resetb), .bus(b1));
    scs8hd_lpflow_pwrseq_ctrl #(.ISO_DLY(1), .RET_DLY(1), .SW_DLY(1), .TMO(1))
        d2 (.clk(clk), .resetb(resetb), .bus(b2));

    // {sleep_ack, iso_en, ret_save, ret_restore, sw_enb, busy, err}
    logic [6:0] o0, o1, o2;
    assign o0 = {b0.sleep_ack, b0.iso_en, b0.ret_save, b0.ret_restore, b0.sw_enb, b0.busy, b0.err};
    assign o1 = {b1.sleep_ack, b1.iso_en, b1.ret_save, b1.ret_restore, b1.sw_enb, b1.busy, b1.err};
    assign o2 = {b2.sleep_ack, b2.iso_en, b2.ret_save, b2.ret_restore, b2.sw_enb, b2.busy, b2.err};

    localparam logic [6:0] X_ON      = 7'b0000000;
    localparam logic [6:0] X_ISO     = 7'b0100010;
    localparam logic [6:0] X_SAVE    = 7'b0110010;
    localparam logic [6:0] X_SWOFF   = 7'b0100110;
    localparam logic [6:0] X_OFF     = 7'b1100100;
    localparam logic [6:0] X_SWON    = 7'b0100010;
    localparam logic [6:0] X_RESTORE = 7'b0101010;
    localparam logic [6:0] X_DEISO   = 7'b0100010;

    typedef struct packed {
        logic       req;
        logic       pg;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl [23];
    int n_chk  = 0;
    int n_pass = 0;
    int viol   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    endtask

    // Structural invariants on every DUT, sampled away from the edge
    always @(negedge clk) begin
        if ((b0.ret_save && b0.ret_restore) || (b0.sw_enb && !b0.iso_en) || (b0.busy && b0.sleep_ack) ||
            (b1.ret_save && b1.ret_restore) || (b1.sw_enb && !b1.iso_en) || (b1.busy && b1.sleep_ack) ||
            (b2.ret_save && b2.ret_restore) || (b2.sw_enb && !b2.iso_en) || (b2.busy && b2.sleep_ack))
            viol <= viol + 1;
    end

    initial begin
        int lat;

        // Full default-parameter sleep then wake, one entry per edge
        for (int i = 0; i < 12; i++) tbl[i] = {1'b1, 1'b1, X_SWOFF};
        tbl[0]  = {1'b1, 1'b1, X_ISO};
        tbl[1]  = {1'b1, 1'b1, X_ISO};
        tbl[2]  = {1'b1, 1'b1, X_SAVE};
        tbl[3]  = {1'b1, 1'b1, X_SAVE};
        for (int i = 4; i < 12; i++) tbl[i] = {1'b1, 1'b0, X_SWOFF};
        tbl[12] = {1'b1, 1'b0, X_OFF};
        tbl[13] = {1'b1, 1'b0, X_OFF};
        tbl[14] = {1'b0, 1'b0, X_SWON};
        tbl[15] = {1'b0, 1'b0, X_SWON};
        tbl[16] = {1'b0, 1'b0, X_SWON};
        tbl[17] = {1'b0, 1'b1, X_RESTORE};
        tbl[18] = {1'b0, 1'b1, X_RESTORE};
        tbl[19] = {1'b0, 1'b1, X_DEISO};
        tbl[20] = {1'b0, 1'b1, X_DEISO};
        tbl[21] = {1'b0, 1'b1, X_ON};
        tbl[22] = {1'b0, 1'b1, X_ON};

        b0.sleep_req = 1'b0; b0.pwr_good = 1'b1;
        b1.sleep_req = 1'b0; b1.pwr_good = 1'b1;
        b2.sleep_req = 1'b0; b2.pwr_good = 1'b1;

        // Reset state
        resetb = 1'b0;
        step();
        step();
        chk("reset_d0", o0, X_ON);
        chk("reset_d1", o1, X_ON);
        chk("reset_d2", o2, X_ON);
        resetb = 1'b1;

        for (int i = 0; i < 23; i++) begin
            b0.sleep_req = tbl[i].req;
            b0.pwr_good  = tbl[i].pg;
            step();
            chk($sformatf("vec%0d", i), o0, tbl[i].exp);
        end

        // One-cycle request pulse: full shutdown, ack one cycle, wake
        b0.pwr_good  = 1'b1;
        b0.sleep_req = 1'b1;
        step();
        chk("pulse_iso", o0, X_ISO);
        b0.sleep_req = 1'b0;
        lat = 1;
        while (!b0.sleep_ack && lat < 100) begin
            step();
            lat++;
        end
        chk("pulse_latency", lat, 13);
        step();
        chk("pulse_ack_once", o0, X_SWON);
        lat = 0;
        while (b0.busy && lat < 50) begin
            step();
            lat++;
        end
        chk("pulse_back_on", o0, X_ON);

        // pwr_good timeout with TMO=4
        b1.sleep_req = 1'b1;
        lat = 0;
        while (!b1.sleep_ack && lat < 100) begin
            step();
            lat++;
        end
        chk("tmo_reach_off", o1, X_OFF);
        b1.pwr_good  = 1'b0;
        b1.sleep_req = 1'b0;
        step();
        chk("tmo_swon_entry", o1, X_SWON);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("tmo_noerr%0d", k), o1, X_SWON);
        end
        step();
        chk("tmo_err_set", o1, X_SWON | 7'b0000001);
        for (int k = 0; k < 6; k++) step();
        chk("tmo_hold_swon", o1, X_SWON | 7'b0000001);
        b1.pwr_good = 1'b1;
        step();
        chk("tmo_restore", o1, X_RESTORE | 7'b0000001);
        lat = 0;
        while (b1.busy && lat < 50) begin
            step();
            lat++;
        end
        chk("tmo_on_err_sticky", o1, 7'b0000001);

        // Reset during SWOFF, then during OFF
        b1.sleep_req = 1'b1;
        lat = 0;
        while (!b1.sw_enb && lat < 50) begin
            step();
            lat++;
        end
        chk("rst_reach_swoff", o1, X_SWOFF | 7'b0000001);
        resetb = 1'b0;
        step();
        chk("rst_swoff", o1, X_ON);
        resetb = 1'b1;
        lat = 0;
        while (!b1.sleep_ack && lat < 100) begin
            step();
            lat++;
        end
        chk("rst_err_cleared_off", o1, X_OFF);
        resetb = 1'b0;
        step();
        chk("rst_off", o1, X_ON);
        b1.sleep_req = 1'b0;
        resetb = 1'b1;
        step();
        chk("rst_release_on", o1, X_ON);

        // All parameters 1: every timed stage is a single cycle
        b2.sleep_req = 1'b1;
        step(); chk("p1_iso",   o2, X_ISO);
        step(); chk("p1_save",  o2, X_SAVE);
        step(); chk("p1_swoff", o2, X_SWOFF);
        step(); chk("p1_off",   o2, X_OFF);
        b2.sleep_req = 1'b0;
        step(); chk("p1_swon",    o2, X_SWON);
        step(); chk("p1_restore", o2, X_RESTORE);
        step(); chk("p1_deiso",   o2, X_DEISO);
        step(); chk("p1_on",      o2, X_ON);

        chk("invariants", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
